// File: rtl/tcp_stream_encoder.sv
// Serialises a TCP header, option words and payload onto a 32-bit valid/ready stream,
// accumulating the one's-complement checksum. Macro TCP_ENC_PSEUDO_HDR_EN seeds it with the IPv4 pseudo-header.
module tcp_stream_encoder #(
  parameter int MAX_OPT_WORDS = 10,
  parameter int LEN_W         = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic [15:0]                src_port,
  input  logic [15:0]                dest_port,
  input  logic [31:0]                seq_num,
  input  logic [31:0]                ack_num,
  input  logic [5:0]                 flags,
  input  logic [15:0]                window,
  input  logic [15:0]                urg_ptr,
  input  logic [MAX_OPT_WORDS*32-1:0] opt_words,
  input  logic [3:0]                 opt_len,
  input  logic [LEN_W-1:0]           len_in,
  input  logic [31:0]                src_ip,
  input  logic [31:0]                dst_ip,
  input  logic [31:0]                in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [31:0]                out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic [3:0]                 out_keep,
  output logic                       busy,
  output logic                       done,
  output logic [15:0]                checksum_out,
  output logic [15:0]                len_out
);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_OPT, S_DATA, S_DONE} state_e;

  state_e state_q, state_d;

  logic [15:0]      src_port_q, dest_port_q, window_q, urg_ptr_q;
  logic [31:0]      seq_q, ack_q;
  logic [5:0]       flags_q;
  logic [3:0]       n_q;
  logic [LEN_W-1:0] len_q;
  logic [31:0]      opt_q [MAX_OPT_WORDS];

  logic [3:0]       cnt_q, cnt_d;
  logic [LEN_W-1:0] left_q, left_d;
  logic [31:0]      acc_q, acc_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;
  logic [3:0]       out_keep_q, out_keep_d;
  logic [15:0]      cks_q, cks_d;
  logic [15:0]      len_out_q, len_out_d;

  logic        take, load, last_hs;
  logic [3:0]  n_in;
  logic [15:0] seg_len_in;
  logic [31:0] seed;
  logic [31:0] hdr_word;
  logic [16:0] fold1;
  logic [15:0] fold2;

  logic        emit, emit_last;
  logic [31:0] emit_word;
  logic [3:0]  emit_keep;

  function automatic logic [15:0] seg_len(input logic [3:0] n, input logic [LEN_W-1:0] len);
    return 16'(32'd20 + 32'(n) * 32'd4 + 32'(len));
  endfunction

  // End-around-carry add of both halves; a second carry cannot occur.
  function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] w);
    logic [33:0] s;
    s = 34'(acc) + 34'(w[31:16]) + 34'(w[15:0]);
    return s[31:0] + 32'(s[33:32]);
  endfunction

  assign take       = (state_q == S_IDLE) && start;
  assign load       = !out_valid_q || out_ready;
  assign last_hs    = out_valid_q && out_ready && out_last_q;
  assign n_in       = (opt_len > 4'(MAX_OPT_WORDS)) ? 4'(MAX_OPT_WORDS) : opt_len;
  assign seg_len_in = seg_len(n_in, len_in);
  assign fold1      = 17'(acc_q[31:16]) + 17'(acc_q[15:0]);
  assign fold2      = fold1[15:0] + 16'(fold1[16]);

`ifdef TCP_ENC_PSEUDO_HDR_EN
  assign seed = 32'(src_ip[31:16]) + 32'(src_ip[15:0]) + 32'(dst_ip[31:16]) +
                32'(dst_ip[15:0]) + 32'h0000_0006 + 32'(seg_len_in);
`else
  logic unused_ip;
  assign unused_ip = ^{src_ip, dst_ip, seg_len_in};
  assign seed      = '0;
`endif

  // NOTE: segment fields and option storage have no reset; nothing reads them before a start loads them.
  always_ff @(posedge clk) begin
    if (take) begin
      src_port_q  <= src_port;
      dest_port_q <= dest_port;
      seq_q       <= seq_num;
      ack_q       <= ack_num;
      flags_q     <= flags;
      window_q    <= window;
      urg_ptr_q   <= urg_ptr;
      n_q         <= n_in;
      len_q       <= len_in;
      for (int k = 0; k < MAX_OPT_WORDS; k++) opt_q[k] <= opt_words[32*k +: 32];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_HDR;
      S_HDR: begin
        if (last_hs) state_d = S_DONE;
        else if (load && cnt_q == 4'd4) begin
          if (n_q != 4'd0)             state_d = S_OPT;
          else if (len_q != '0)        state_d = S_DATA;
        end
      end
      S_OPT: begin
        if (last_hs) state_d = S_DONE;
        else if (load && cnt_q == n_q - 4'd1 && len_q != '0) state_d = S_DATA;
      end
      S_DATA:  if (last_hs) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (cnt_q)
      4'd0:    hdr_word = {src_port_q, dest_port_q};
      4'd1:    hdr_word = seq_q;
      4'd2:    hdr_word = ack_q;
      4'd3:    hdr_word = {4'd5 + n_q, 6'd0, flags_q, window_q};
      default: hdr_word = {16'd0, urg_ptr_q};
    endcase
  end

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
  always_comb begin
    emit      = 1'b0;
    emit_last = 1'b0;
    emit_word = '0;
    emit_keep = 4'hF;
    case (state_q)
      S_HDR: if (cnt_q < 4'd5) begin
        emit      = 1'b1;
        emit_word = hdr_word;
        emit_last = (cnt_q == 4'd4) && (n_q == 4'd0) && (len_q == '0);
      end
      S_OPT: if (cnt_q < n_q) begin
        emit      = 1'b1;
        emit_word = opt_q[cnt_q];
        emit_last = (cnt_q == n_q - 4'd1) && (len_q == '0);
      end
      S_DATA: if (in_valid && left_q != '0) begin
        emit      = 1'b1;
        emit_last = (left_q <= LEN_W'(4));
        if (left_q < LEN_W'(4)) begin
          case (left_q[1:0])
            2'd1:    emit_keep = 4'b1000;
            2'd2:    emit_keep = 4'b1100;
            default: emit_keep = 4'b1110;
          endcase
        end
        emit_word = in_data & {{8{emit_keep[3]}}, {8{emit_keep[2]}},
                               {8{emit_keep[1]}}, {8{emit_keep[0]}}};
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    left_d      = left_q;
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_keep_d  = out_keep_q;
    cks_d       = cks_q;
    len_out_d   = len_out_q;
    if (take) begin
      cnt_d  = '0;
      left_d = len_in;
      acc_d  = seed;
    end
    if (load) begin
      out_valid_d = emit;
      if (emit) begin
        out_data_d = emit_word;
        out_last_d = emit_last;
        out_keep_d = emit_keep;
        acc_d      = csum_add(acc_q, emit_word);
        case (state_q)
          S_HDR:   cnt_d  = (cnt_q == 4'd4 && n_q != 4'd0) ? 4'd0 : cnt_q + 4'd1;
          S_OPT:   cnt_d  = cnt_q + 4'd1;
          default: left_d = (left_q < LEN_W'(4)) ? '0 : left_q - LEN_W'(4);
        endcase
      end
    end
    if (last_hs) begin
      cks_d     = ~fold2;
      len_out_d = seg_len(n_q, len_q);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      left_q      <= '0;
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      cks_q       <= '0;
      len_out_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_keep_q  <= out_keep_d;
      cks_q       <= cks_d;
      len_out_q   <= len_out_d;
    end
  end

  assign in_ready     = (state_q == S_DATA) && (left_q != '0) && load;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign out_last     = out_last_q;
  assign out_keep     = out_keep_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = (state_q == S_DONE);
  assign checksum_out = cks_q;
  assign len_out      = len_out_q;

endmodule

// File: tb/tb_tcp_stream_encoder.sv
// Randomised self-checking bench for tcp_stream_encoder against a segment-level reference model.
module tb_tcp_stream_encoder;
  localparam int MAXW = 10;

  logic               clk = 1'b0;
  logic               reset;
  logic               start;
  logic [15:0]        src_port, dest_port, window, urg_ptr;
  logic [31:0]        seq_num, ack_num;
  logic [5:0]         flags;
  logic [MAXW*32-1:0] opt_words;
  logic [3:0]         opt_len;
  logic [15:0]        len_in;
  logic [31:0]        src_ip, dst_ip;
  logic [31:0]        in_data;
  logic               in_valid, in_ready;
  logic [31:0]        out_data;
  logic               out_valid, out_ready, out_last;
  logic [3:0]         out_keep;
  logic               busy, done;
  logic [15:0]        checksum_out, len_out;

  tcp_stream_encoder #(.MAX_OPT_WORDS(MAXW), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start),
    .src_port(src_port), .dest_port(dest_port), .seq_num(seq_num), .ack_num(ack_num),
    .flags(flags), .window(window), .urg_ptr(urg_ptr),
    .opt_words(opt_words), .opt_len(opt_len), .len_in(len_in),
    .src_ip(src_ip), .dst_ip(dst_ip),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_keep(out_keep),
    .busy(busy), .done(done), .checksum_out(checksum_out), .len_out(len_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  // Segment under test
  logic [15:0] s_src, s_dst, s_win, s_urg;
  logic [31:0] s_seq, s_ack, s_sip, s_dip;
  logic [5:0]  s_flags;
  logic [3:0]  s_opt_len;
  int          s_len;
  logic [31:0] s_opt [MAXW];
  logic [7:0]  pay [$];

  word_t       exp_q [$];
  logic [31:0] in_q [$];
  logic [15:0] exp_cks, exp_len;

  logic [15:0] got_cks, got_len;
  int          done_it;

  task automatic build_model();
    int n, nw, total, idx;
    longint unsigned sum;
    logic [31:0] w, raw;
    logic [3:0]  k;
    logic [7:0]  b;
    word_t       e;
    exp_q.delete();
    in_q.delete();
    n     = (int'(s_opt_len) > MAXW) ? MAXW : int'(s_opt_len);
    nw    = (s_len + 3) / 4;
    total = 5 + n + nw;
    idx   = 0;
    for (int i = 0; i < total; i++) begin
      k = 4'hF;
      if (i == 0)      w = {s_src, s_dst};
      else if (i == 1) w = s_seq;
      else if (i == 2) w = s_ack;
      else if (i == 3) w = {4'(5 + n), 6'd0, s_flags, s_win};
      else if (i == 4) w = {16'd0, s_urg};
      else if (i < 5 + n) w = s_opt[i - 5];
      else begin
        w = '0; raw = '0; k = '0;
        for (int j = 0; j < 4; j++) begin
          idx = 4 * (i - 5 - n) + j;
          b = (idx < s_len) ? pay[idx] : 8'($urandom);
          raw[31 - 8*j -: 8] = b;
          if (idx < s_len) begin
            w[31 - 8*j -: 8] = b;
            k[3 - j] = 1'b1;
          end
        end
        in_q.push_back(raw);
      end
      e.data = w; e.keep = k; e.last = (i == total - 1);
      exp_q.push_back(e);
    end
    exp_len = 16'(20 + 4 * n + s_len);
    sum = 0;
    foreach (exp_q[i]) sum += longint'(exp_q[i].data[31:16]) + longint'(exp_q[i].data[15:0]);
`ifdef TCP_ENC_PSEUDO_HDR_EN
    sum += longint'(s_sip[31:16]) + longint'(s_sip[15:0]) + longint'(s_dip[31:16]) +
           longint'(s_dip[15:0]) + 64'd6 + longint'(exp_len);
`endif
    while ((sum >> 16) != 0) sum = (sum & 64'hFFFF) + (sum >> 16);
    exp_cks = ~sum[15:0];
  endtask

  task automatic drive_fields();
    src_port = s_src; dest_port = s_dst; seq_num = s_seq; ack_num = s_ack;
    flags = s_flags; window = s_win; urg_ptr = s_urg;
    for (int k = 0; k < MAXW; k++) opt_words[32*k +: 32] = s_opt[k];
    opt_len = s_opt_len; len_in = 16'(s_len); src_ip = s_sip; dst_ip = s_dip;
  endtask

  task automatic rand_seg(input int max_len);
    s_src = 16'($urandom); s_dst = 16'($urandom); s_seq = $urandom; s_ack = $urandom;
    s_flags = 6'($urandom); s_win = 16'($urandom); s_urg = 16'($urandom);
    s_sip = $urandom; s_dip = $urandom;
    s_opt_len = 4'($urandom_range(0, 15));
    for (int k = 0; k < MAXW; k++) s_opt[k] = $urandom;
    s_len = $urandom_range(0, max_len);
    pay.delete();
    for (int i = 0; i < s_len; i++) pay.push_back(8'($urandom));
  endtask

  // rmode: 0 = out_ready/in_valid always high, 1 = out_ready toggles, 2 = random.
  // abort_at >= 0: assert reset once that many words have been accepted.
  task automatic run_segment(input int rmode, input int abort_at);
    int          it, fed, hs;
    logic        last_hs, done_seen, finished, stall_prev;
    logic [37:0] held;
    word_t       e;
    it = 0; fed = 0; hs = 0;
    last_hs = 0; done_seen = 0; finished = 0; stall_prev = 0; held = '0;
    done_it = -1;
    @(negedge clk);
    drive_fields();
    start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    while (!finished && it < 600) begin
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(it % 2) : 1'($urandom_range(0, 1));
      in_valid  = (fed < in_q.size()) && (rmode == 0 || $urandom_range(0, 3) != 0);
      in_data   = in_valid ? in_q[fed] : $urandom;
      start     = (rmode == 2) && !done_seen && ($urandom_range(0, 7) == 0);
      if (start) begin
        src_port = 16'($urandom); seq_num = $urandom; opt_len = 4'($urandom);
        len_in = 16'($urandom); flags = 6'($urandom); src_ip = $urandom;
      end
      #1;
      if (it == 0) check("start_lat0", {busy, out_valid}, 2'b10);
      if (it == 1) check("start_lat1", {out_valid, out_data}, {1'b1, exp_q[0].data});
      if (stall_prev) check("hold_stable", {out_valid, out_last, out_keep, out_data}, held);
      if (out_valid && !out_ready) check("in_ready_stall", in_ready, 1'b0);
      if (done || last_hs) check("done_pulse", done, last_hs);
      if (done_seen && !done) begin
        check("idle_after_done", busy, 1'b0);
        finished = 1;
      end
      if (done) begin
        got_cks = checksum_out; got_len = len_out;
        check("checksum", checksum_out, exp_cks);
        check("len_out", len_out, exp_len);
        done_seen = 1; done_it = it;
      end
      if (in_valid && in_ready) fed++;
      last_hs = 0;
      if (out_valid && out_ready) begin
        hs++;
        if (exp_q.size() == 0) check("extra_word", out_data, 0);
        else begin
          e = exp_q.pop_front();
          check("word", {out_last, out_keep, out_data}, {e.last, e.keep, e.data});
          last_hs = out_last;
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {out_valid, out_last, out_keep, out_data};
      if (abort_at >= 0 && hs == abort_at && out_valid) begin
        #1 reset = 1'b0;
        #1 check("abort_outputs",
                 {out_data, out_valid, out_last, out_keep, in_ready, busy, done, checksum_out, len_out},
                 73'd0);
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          if (c == 2) reset = 1'b1;
          #1 check("abort_no_done", {busy, done}, 2'b00);
        end
        return;
      end
      @(negedge clk);
      it++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (!finished) check("timeout", 1'b0, 1'b1);
    check("all_words", exp_q.size(), 0);
    check("all_fed", fed, in_q.size());
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    src_port = '0; dest_port = '0; seq_num = '0; ack_num = '0; flags = '0;
    window = '0; urg_ptr = '0; opt_words = '0; opt_len = '0; len_in = '0;
    src_ip = '0; dst_ip = '0;
    #12;
    check("reset_state",
          {out_data, out_valid, out_last, out_keep, in_ready, busy, done, checksum_out, len_out},
          73'd0);
    @(negedge clk) reset = 1'b1;

    // Minimal SYN (pseudo-header build: same segment with IPs)
    s_src = 16'h1234; s_dst = 16'h0050; s_seq = '0; s_ack = '0; s_flags = 6'b000010;
    s_win = 16'hFFFF; s_urg = '0; s_opt_len = 4'd0; s_len = 0; pay.delete();
    s_sip = 32'h0A00_0001; s_dip = 32'h0A00_0002;
    for (int k = 0; k < MAXW; k++) s_opt[k] = '0;
    build_model();
    run_segment(0, -1);
    check("syn_done_cycle", done_it, 6);
    check("syn_len", got_len, 16'd20);
`ifndef TCP_ENC_PSEUDO_HDR_EN
    check("syn_cks_const", got_cks, 16'h9D79);
`endif

    // Short payload: 5 bytes, garbage in the tail of the second word
    s_len = 5; pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    build_model();
    in_q[1] = 32'hEEFF_0011;
    run_segment(0, -1);
    check("short_len", got_len, 16'd25);

    // Option count clamp: 15 requested, 10 held
    rand_seg(12);
    s_opt_len = 4'd15;
    build_model();
    run_segment(0, -1);
    check("clamp_len", got_len, 16'(60 + s_len));

    // Backpressure: out_ready toggling every cycle
    rand_seg(0);
    s_opt_len = 4'd2; s_len = 17;
    for (int i = 0; i < s_len; i++) pay.push_back(8'($urandom));
    build_model();
    run_segment(1, -1);

    // Payload length boundaries 1..8
    for (int l = 1; l <= 8; l++) begin
      rand_seg(0);
      s_len = l;
      for (int i = 0; i < s_len; i++) pay.push_back(8'($urandom));
      build_model();
      run_segment(2, -1);
    end

    // Abort during option word 1, then recovery
    rand_seg(8);
    s_opt_len = 4'd3;
    build_model();
    run_segment(0, 6);
    rand_seg(20);
    build_model();
    run_segment(2, -1);

    // Random segments with random stalls and ignored start pulses
    for (int r = 0; r < 40; r++) begin
      rand_seg(40);
      build_model();
      run_segment(2, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
